byte_packer: RTL and testbench

Serial-to-parallel word assembler. It accepts one 8-bit byte per cycle over a valid/ready handshake, packs four consecutive bytes into a 32-bit word, and presents the word on a valid/ready output port. It is the inverse of the word-to-byte splitter in the P1 datapath and sits upstream of any 32-bit consumer fed from a byte-wide stream.

---
 rtl/byte_packer.sv | 64 ++++++
 tb/tb_byte_packer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
// byte_packer: assembles four consecutive 8-bit bytes into one 32-bit word.
// Byte input and word output both use a valid/ready handshake.
// Build option: define BYTE_PACKER_LE_EN for little-endian lane placement
// (first byte in [7:0]); the default is big-endian (first byte in [31:24]).
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  cnt
);

    logic        accept;
    logic        xfer;
    logic [1:0]  lane;
    logic [31:0] word_next;

    // A held word blocks input unless it leaves in this same cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !clr;
    assign xfer     = out_valid && out_ready;

`ifdef BYTE_PACKER_LE_EN
    assign lane = cnt;
`else
    assign lane = 2'd3 - cnt;
`endif

    // Merge the incoming byte into its lane; the first byte of a word starts from zero.
    always_comb begin
        word_next = (cnt == 2'd0) ? '0 : out_word;
        word_next[{lane, 3'b000} +: 8] = in_byte;
    end

    // Partial-word register, byte counter and output-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word  <= '0;
            out_valid <= 1'b0;
            cnt       <= 2'd0;
        end else if (clr) begin
            out_word  <= '0;
            out_valid <= 1'b0;
            cnt       <= 2'd0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                out_word <= word_next;
                cnt      <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: scoreboard of expected words plus
// per-scenario inline checks. Define BYTE_PACKER_LE_EN for the LE build.
module tb_byte_packer;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    byte_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt       (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference packing of four bytes, first byte b0.
    function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
`ifdef BYTE_PACKER_LE_EN
        return {b3, b2, b1, b0};
`else
        return {b0, b1, b2, b3};
`endif
    endfunction

    // Scoreboard: a word transfers at the next rising edge when valid && ready here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_word: unexpected word %h, none required", out_word);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_word !== e) begin
                    failures++;
                    $display("FAIL sb_word: got %h required %h", out_word, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_byte = '0; out_ready = 1'b1;
        tick(); tick();
        checks++; if (out_word !== 32'h0) begin failures++; $display("FAIL rst_word: got %h required %h", out_word, 32'h0); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", out_valid); end
        checks++; if (cnt !== 2'd0) begin failures++; $display("FAIL rst_cnt: got %0d required 0", cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] b[4];
        b[0] = 8'hFF; b[1] = 8'hFE; b[2] = 8'hFD; b[3] = 8'hF7;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_byte = b[i];
            if (i == 3) exp_q.push_back(pack(b[0], b[1], b[2], b[3]));
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b required 1", out_valid); end
        checks++; if (out_word !== pack(8'hFF, 8'hFE, 8'hFD, 8'hF7)) begin
            failures++; $display("FAIL basic_word: got %h required %h", out_word, pack(8'hFF, 8'hFE, 8'hFD, 8'hF7)); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop: got %b required 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] b[4];
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_byte = b[i];
            if (i == 3) exp_q.push_back(pack(b[0], b[1], b[2], b[3]));
            tick();
        end
        in_byte = 8'h55;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready); end
            checks++; if (out_word !== pack(8'h11, 8'h22, 8'h33, 8'h44)) begin
                failures++; $display("FAIL bp_word[%0d]: got %h required %h", i, out_word, pack(8'h11, 8'h22, 8'h33, 8'h44)); end
            checks++; if (cnt !== 2'd0) begin failures++; $display("FAIL bp_cnt[%0d]: got %0d required 0", i, cnt); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
        tick();
        checks++; if (cnt !== 2'd1) begin failures++; $display("FAIL bp_cnt_after: got %0d required 1", cnt); end
        checks++; if (out_word !== pack(8'h55, 8'h00, 8'h00, 8'h00)) begin
            failures++; $display("FAIL bp_word_after: got %h required %h", out_word, pack(8'h55, 8'h00, 8'h00, 8'h00)); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_after: got %b required 0", out_valid); end
        in_byte = 8'h66; tick();
        in_byte = 8'h77; tick();
        in_byte = 8'h88; exp_q.push_back(pack(8'h55, 8'h66, 8'h77, 8'h88)); tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_second_valid: got %b required 1", out_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_byte = 8'(i + 1);
            if (i == 3) exp_q.push_back(pack(8'h01, 8'h02, 8'h03, 8'h04));
            if (i == 7) exp_q.push_back(pack(8'h05, 8'h06, 8'h07, 8'h08));
            tick();
            exp_v = (i == 3) || (i == 7);
            checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL b2b_valid[%0d]: got %b required %b", i, out_valid, exp_v); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d]: got %b required 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_end: got %b required 0", out_valid); end
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        in_valid = 1'b1; in_byte = 8'hAA; tick();
        in_byte = 8'hBB; tick();
        checks++; if (cnt !== 2'd2) begin failures++; $display("FAIL clr_cnt_before: got %0d required 2", cnt); end
        clr = 1'b1; in_byte = 8'hCC; tick();
        clr = 1'b0;
        checks++; if (cnt !== 2'd0) begin failures++; $display("FAIL clr_cnt: got %0d required 0", cnt); end
        checks++; if (out_word !== 32'h0) begin failures++; $display("FAIL clr_word: got %h required 0", out_word); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_valid: got %b required 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            in_byte = 8'(i + 1);
            if (i == 3) exp_q.push_back(pack(8'h01, 8'h02, 8'h03, 8'h04));
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_word !== pack(8'h01, 8'h02, 8'h03, 8'h04)) begin
            failures++; $display("FAIL clr_next_word: got %h required %h", out_word, pack(8'h01, 8'h02, 8'h03, 8'h04)); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_byte = 8'h9A; tick();
        in_byte = 8'hBC; tick();
        in_byte = 8'hDE; tick();
        in_valid = 1'b0;
        checks++; if (cnt !== 2'd3) begin failures++; $display("FAIL ar_cnt_before: got %0d required 3", cnt); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cnt !== 2'd0) begin failures++; $display("FAIL ar_cnt: got %0d required 0", cnt); end
        checks++; if (out_word !== 32'h0) begin failures++; $display("FAIL ar_word: got %h required 0", out_word); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready: got %b required 1", in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d words still pending, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
